// File: rtl/mux6_rr_sched_pkg.sv
// mux6_sched_pkg: shared definitions for the six-way round-robin scheduler.
//   NUM_REQ / SEL_W : requester count and source-index width
//   sel_t           : 3-bit source index type
//   buf_state_t     : output buffer state (EMPTY / FULL)
//   next_idx()      : index + 1, modulo NUM_REQ
package mux6_sched_pkg;

    localparam int unsigned NUM_REQ = 6;
    localparam int unsigned SEL_W   = 3;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    // Codes at or above NUM_REQ-1 wrap to 0, so stray codes 6/7 also land on 0.
    function automatic sel_t next_idx(input sel_t idx);
        if (idx >= sel_t'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + sel_t'(1);
    endfunction

endpackage

// File: rtl/mux6_rr_sched_if.sv
// mux6_rr_sched_if: request/response bundle for mux6_rr_sched.
//   req_valid/req_ready : per-requester handshake (6 bits each)
//   data0..data5        : requester payloads
//   out_valid/out_ready : downstream handshake
//   out_data/out_sel    : buffered payload and its source index
//   lock                : per-requester lock request (MUX6_SCHED_LOCK_EN only)
// Modports: slave = scheduler side, master = requester/consumer side.
import mux6_sched_pkg::*;

interface mux6_rr_sched_if #(
    parameter int unsigned DATA_W = 4
);

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [DATA_W-1:0]  data0;
    logic [DATA_W-1:0]  data1;
    logic [DATA_W-1:0]  data2;
    logic [DATA_W-1:0]  data3;
    logic [DATA_W-1:0]  data4;
    logic [DATA_W-1:0]  data5;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    sel_t               out_sel;
`ifdef MUX6_SCHED_LOCK_EN
    logic [NUM_REQ-1:0] lock;

    modport slave (
        input  req_valid, data0, data1, data2, data3, data4, data5,
        input  out_ready, lock,
        output req_ready, out_valid, out_data, out_sel
    );

    modport master (
        output req_valid, data0, data1, data2, data3, data4, data5,
        output out_ready, lock,
        input  req_ready, out_valid, out_data, out_sel
    );
`else
    modport slave (
        input  req_valid, data0, data1, data2, data3, data4, data5,
        input  out_ready,
        output req_ready, out_valid, out_data, out_sel
    );

    modport master (
        output req_valid, data0, data1, data2, data3, data4, data5,
        output out_ready,
        input  req_ready, out_valid, out_data, out_sel
    );
`endif

endinterface

// File: rtl/mux6_rr_sched_rr_pick6.sv
// rr_pick6: combinational round-robin picker over six requests.
//   req    in  6 : request mask
//   ptr    in  3 : highest-priority index (0..5)
//   any    out 1 : at least one request set
//   winner out 3 : first set index scanning ptr, ptr+1, ... modulo 6
import mux6_sched_pkg::*;

module rr_pick6 (
    input  logic [NUM_REQ-1:0] req,
    input  sel_t               ptr,
    output logic               any,
    output sel_t               winner
);

    sel_t idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/mux6_rr_sched.sv
// mux6_rr_sched: six-requester round-robin scheduler feeding a single-entry
// output buffer.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mux6_rr_sched_if.slave (requester handshakes, payloads, output port)
// Optional feature: define MUX6_SCHED_LOCK_EN to add the lock input and an
// owner register that restricts winning to the lock holder.
import mux6_sched_pkg::*;

module mux6_rr_sched #(
    parameter int unsigned DATA_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux6_rr_sched_if.slave bus
);

    buf_state_t         state_q;
    buf_state_t         state_d;
    sel_t               ptr_q;
    sel_t               sel_q;
    logic [DATA_W-1:0]  data_q;

    logic [NUM_REQ-1:0] req_masked;
    logic [NUM_REQ-1:0] grant;
    logic               any;
    sel_t               winner;
    logic               can_accept;
    logic               accept;
    logic [DATA_W-1:0]  mux_data;

`ifdef MUX6_SCHED_LOCK_EN
    logic lock_vld_q;
    sel_t lock_id_q;

    // The owner keeps exclusive access even while it is not requesting.
    always_comb begin
        req_masked = bus.req_valid;
        if (lock_vld_q) begin
            req_masked = bus.req_valid & (6'b000001 << lock_id_q);
        end
    end

    // While locked only the owner can win, so lock[winner] alone decides
    // whether the lock is taken, kept or released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
        end else if (accept) begin
            lock_vld_q <= bus.lock[winner];
            if (bus.lock[winner]) begin
                lock_id_q <= winner;
            end
        end
    end
`else
    always_comb begin
        req_masked = bus.req_valid;
    end
`endif

    rr_pick6 u_pick (
        .req    (req_masked),
        .ptr    (ptr_q),
        .any    (any),
        .winner (winner)
    );

    // Buffer FSM and grant.
    always_comb begin
        state_d    = state_q;
        grant      = '0;
        can_accept = (state_q == EMPTY) || bus.out_ready;
        accept     = any && can_accept;
        if (accept) begin
            grant[winner] = 1'b1;
        end
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bus.out_ready && !accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Data steering; codes 6 and 7 are never granted.
    always_comb begin
        case (winner)
            3'd0:    mux_data = bus.data0;
            3'd1:    mux_data = bus.data1;
            3'd2:    mux_data = bus.data2;
            3'd3:    mux_data = bus.data3;
            3'd4:    mux_data = bus.data4;
            3'd5:    mux_data = bus.data5;
            default: mux_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q  <= next_idx(winner);
                sel_q  <= winner;
                data_q <= mux_data;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = (state_q == FULL) ? data_q : '0;
    assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_mux6_rr_sched.sv
// tb_mux6_rr_sched: self-checking bench for mux6_rr_sched. A behavioural
// model predicts grants; accepted beats go into a scoreboard queue and are
// compared against the output buffer each cycle. Directed checks cover the
// single-request, round-robin, backpressure, empty, reset and lock cases.
`timescale 1ns/1ps

module tb_mux6_rr_sched;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d [6];

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    beat_t sb [$];
    int    m_ptr      = 0;
    int    m_last_sel = 0;
    bit    m_full     = 1'b0;
    bit    m_lock_vld = 1'b0;
    int    m_lock_id  = 0;

    mux6_rr_sched_if #(.DATA_W(4)) bus ();

    mux6_rr_sched #(.DATA_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.data0 = d[0];
    assign bus.data1 = d[1];
    assign bus.data2 = d[2];
    assign bus.data3 = d[3];
    assign bus.data4 = d[4];
    assign bus.data5 = d[5];

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr      = 0;
        m_last_sel = 0;
        m_full     = 1'b0;
        m_lock_vld = 1'b0;
        m_lock_id  = 0;
    endtask

    // One clock: check at the falling edge, advance the model, return #1
    // after the next rising edge.
    task automatic cycle();
        logic [5:0] mask;
        logic [5:0] reqs;
        logic [5:0] exp_rr;
        logic [5:0] lk;
        int  win;
        bit  found;
        bit  acc;
        int  i;
        @(negedge clk);
        lk = '0;
`ifdef MUX6_SCHED_LOCK_EN
        lk = bus.lock;
`endif
        mask  = m_lock_vld ? (6'b000001 << m_lock_id) : 6'b111111;
        reqs  = bus.req_valid & mask;
        found = 1'b0;
        win   = 0;
        i     = m_ptr;
        repeat (6) begin
            if (!found && reqs[i]) begin
                found = 1'b1;
                win   = i;
            end
            i = (i == 5) ? 0 : i + 1;
        end
        acc    = found && (!m_full || bus.out_ready);
        exp_rr = acc ? (6'b000001 << win) : 6'b000000;

        check("req_ready", 32'(bus.req_ready), 32'(exp_rr));
        check("out_valid", 32'(bus.out_valid), 32'(m_full));
        if (m_full && sb.size() > 0) begin
            check("out_sel",  32'(bus.out_sel),  32'(sb[0].sel));
            check("out_data", 32'(bus.out_data), 32'(sb[0].data));
        end else begin
            check("empty_data", 32'(bus.out_data), 32'd0);
            check("empty_sel",  32'(bus.out_sel),  32'(m_last_sel));
        end

        if (m_full && bus.out_ready) begin
            void'(sb.pop_front());
            m_full = 1'b0;
        end
        if (acc) begin
            sb.push_back('{sel: 3'(win), data: d[win]});
            m_full     = 1'b1;
            m_ptr      = (win == 5) ? 0 : win + 1;
            m_last_sel = win;
            m_lock_vld = lk[win];
            if (lk[win]) m_lock_id = win;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
`ifdef MUX6_SCHED_LOCK_EN
        bus.lock = '0;
`endif
        for (int k = 0; k < 6; k++) d[k] = 4'(k + 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        // Reset state
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);
        check("rst_sel",   32'(bus.out_sel),   32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        cycle();

        // Round-robin and wrap
        bus.req_valid = 6'b111111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rr_sel",  32'(bus.out_sel),  32'(k % 6));
            check("rr_data", 32'(bus.out_data), 32'(k % 6 + 1));
        end

        // Single request (ptr is 2 here, buffer popped in the same cycle)
        bus.req_valid = 6'b000100;
        d[2] = 4'hA;
        #1;
        check("single_grant", 32'(bus.req_ready), 32'h04);
        cycle();
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_data",  32'(bus.out_data),  32'hA);
        check("single_sel",   32'(bus.out_sel),   32'd2);

        // Backpressure: fill with requester 4, then stall with requester 1 waiting
        bus.req_valid = 6'b010000;
        d[4] = 4'h7;
        cycle();
        bus.req_valid = 6'b000010;
        bus.out_ready = 1'b0;
        d[1] = 4'h3;
        repeat (3) begin
            cycle();
            check("bp_ready", 32'(bus.req_ready), 32'd0);
            check("bp_sel",   32'(bus.out_sel),   32'd4);
            check("bp_data",  32'(bus.out_data),  32'h7);
        end
        bus.out_ready = 1'b1;
        cycle();
        check("bp_release_sel", 32'(bus.out_sel), 32'd1);

        // Empty behaviour
        bus.req_valid = '0;
        repeat (3) cycle();
        check("empty_valid_d", 32'(bus.out_valid), 32'd0);
        check("empty_sel_d",   32'(bus.out_sel),   32'd1);

        // Reset mid-operation while FULL with ptr = 3
        bus.req_valid = 6'b000100;
        d[2] = 4'h5;
        cycle();
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_data",  32'(bus.out_data),  32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 6'b111111;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) d[k] = 4'(k + 1);
        cycle();
        check("arst_first", 32'(bus.out_sel), 32'd0);

`ifdef MUX6_SCHED_LOCK_EN
        // Lock: requester 3 holds the path for three beats; ptr is 1 here
        bus.req_valid = 6'b101001;
        bus.lock      = 6'b001000;
        cycle();
        check("lock_g1", 32'(bus.out_sel), 32'd3);
        cycle();
        check("lock_g2", 32'(bus.out_sel), 32'd3);
        bus.lock = '0;
        cycle();
        check("lock_g3", 32'(bus.out_sel), 32'd3);
        bus.req_valid = 6'b100001;
        cycle();
        check("lock_g4", 32'(bus.out_sel), 32'd5);
        cycle();
        check("lock_g5", 32'(bus.out_sel), 32'd0);
`endif

        bus.req_valid = '0;
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
